// File: rtl/m20k_dp_bank.sv
// rtl/m20k_dp_bank.sv - parametrised true-dual-port RAM bank with bit masks, collision flag and zero-clear sweep
// Array is behavioural so it maps onto M20K; port 0 wins overlapping bits on a same-address dual write.
module m20k_dp_bank #(
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 8192,
    parameter int AW        = 13,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [AW-1:0]    A0,
    input  logic [AW-1:0]    A1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             CE0,
    input  logic             CE1,
    input  logic             WE0,
    input  logic             WE1,
    input  logic [WIDTH-1:0] WEM0,
    input  logic [WIDTH-1:0] WEM1,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             INIT_BUSY,
    output logic             COLL
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic             busy_q;
    logic             coll_q;
    logic [AW-1:0]    cnt_q;
    logic [WIDTH-1:0] s1_0_q, s1_1_q;
    logic [WIDTH-1:0] q0_q, q1_q;
    logic             v0_q, v1_q;

    logic             ready;
    logic             ok0, ok1;
    logic             wr0, wr1, same_wr;
    logic [WIDTH-1:0] old0, old1, new0, new1, both_d;
    logic [WIDTH-1:0] rdata0_d, rdata1_d;

    assign ready = (state_q == READY);
    assign ok0   = ({1'b0, A0} < DEPTH_W);
    assign ok1   = ({1'b0, A1} < DEPTH_W);
    assign wr0   = ready & CE0 & WE0 & ok0;
    assign wr1   = ready & CE1 & WE1 & ok1;
    assign same_wr = wr0 & wr1 & (A0 == A1);

    // Reads see the array before this edge's writes, so the other port always gets old data.
    assign old0   = ok0 ? mem[A0] : '0;
    assign old1   = ok1 ? mem[A1] : '0;
    assign new0   = (old0 & ~WEM0) | (D0 & WEM0);
    assign new1   = (old1 & ~WEM1) | (D1 & WEM1);
    assign both_d = (new1 & ~WEM0) | (D0 & WEM0);

    assign rdata0_d = !ok0 ? '0 : (WE0 ? new0 : old0);
    assign rdata1_d = !ok1 ? '0 : (WE1 ? new1 : old1);

    always_ff @(posedge CLK) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr1 && !same_wr) mem[A1] <= new1;
            if (wr0)             mem[A0] <= same_wr ? both_d : new0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= (INIT_ZERO != 0) ? CLEAR : READY;
            busy_q  <= (INIT_ZERO != 0);
            cnt_q   <= '0;
            coll_q  <= 1'b0;
            s1_0_q  <= '0;
            s1_1_q  <= '0;
            q0_q    <= '0;
            q1_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    coll_q <= 1'b0;
                    v0_q   <= 1'b0;
                    v1_q   <= 1'b0;
                    if (cnt_q == LAST_A) begin
                        cnt_q   <= '0;
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    coll_q <= same_wr;
                    v0_q   <= CE0;
                    v1_q   <= CE1;
                    if (CE0) s1_0_q <= rdata0_d;
                    if (CE1) s1_1_q <= rdata1_d;
                    // Output stage only advances behind a real request so idle cycles hold Q.
                    if (OUT_REG != 0) begin
                        if (v0_q) q0_q <= s1_0_q;
                        if (v1_q) q1_q <= s1_1_q;
                    end
                end
            endcase
        end
    end

    assign Q0        = (OUT_REG != 0) ? q0_q : s1_0_q;
    assign Q1        = (OUT_REG != 0) ? q1_q : s1_1_q;
    assign INIT_BUSY = busy_q;
    assign COLL      = coll_q;

endmodule

// File: tb/tb_m20k_dp_bank.sv
// tb/tb_m20k_dp_bank.sv - self-checking bench for m20k_dp_bank (DEPTH=8 latency 1, DEPTH=6 latency 2)
module tb_m20k_dp_bank;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [2:0] a0 = '0, a1 = '0;
    logic [1:0] d0 = '0, d1 = '0, wem0 = '0, wem1 = '0;
    logic       ce0 = 1'b0, ce1 = 1'b0, we0 = 1'b0, we1 = 1'b0;

    logic [1:0] q0_w [2];
    logic [1:0] q1_w [2];
    logic       busy_w [2];
    logic       coll_w [2];

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    m20k_dp_bank #(.WIDTH(2), .DEPTH(8), .AW(3), .OUT_REG(0), .INIT_ZERO(1)) u_lat1 (
        .CLK(clk), .RSTN(rstn), .A0(a0), .A1(a1), .D0(d0), .D1(d1),
        .CE0(ce0), .CE1(ce1), .WE0(we0), .WE1(we1), .WEM0(wem0), .WEM1(wem1),
        .Q0(q0_w[0]), .Q1(q1_w[0]), .INIT_BUSY(busy_w[0]), .COLL(coll_w[0])
    );

    m20k_dp_bank #(.WIDTH(2), .DEPTH(6), .AW(3), .OUT_REG(1), .INIT_ZERO(1)) u_lat2 (
        .CLK(clk), .RSTN(rstn), .A0(a0), .A1(a1), .D0(d0), .D1(d1),
        .CE0(ce0), .CE1(ce1), .WE0(we0), .WE1(we1), .WEM0(wem0), .WEM1(wem1),
        .Q0(q0_w[1]), .Q1(q1_w[1]), .INIT_BUSY(busy_w[1]), .COLL(coll_w[1])
    );

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    // Reference model: array contents, sweep progress, and responses scheduled by cycle number.
    logic [1:0] mm [2][8];
    int         cnt_m [2];
    logic       coll_e [2];
    logic [1:0] q_e [2][2];
    logic [1:0] sch_v [2][2][4];
    bit         sch_ok [2][2][4];
    int         ncyc = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                cnt_m[k]  = 0;
                coll_e[k] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    q_e[k][p] = '0;
                    for (int s = 0; s < 4; s++) sch_ok[k][p][s] = 1'b0;
                end
            end
        end else begin
            logic       pce [2];
            logic       pwe [2];
            logic [2:0] pa [2];
            logic [1:0] pd [2];
            logic [1:0] pm [2];
            logic [1:0] rv;
            int         due;
            pce[0] = ce0; pce[1] = ce1; pwe[0] = we0; pwe[1] = we1;
            pa[0] = a0; pa[1] = a1; pd[0] = d0; pd[1] = d1; pm[0] = wem0; pm[1] = wem1;
            ncyc++;
            for (int k = 0; k < 2; k++) begin
                if (cnt_m[k] < dep(k)) begin
                    mm[k][cnt_m[k]] = '0;
                    cnt_m[k]++;
                    coll_e[k] = 1'b0;
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        if (pce[p]) begin
                            rv = '0;
                            if (int'(pa[p]) < dep(k)) begin
                                rv = mm[k][pa[p]];
                                if (pwe[p])
                                    for (int i = 0; i < 2; i++) if (pm[p][i]) rv[i] = pd[p][i];
                            end
                            due = (ncyc + ((k == 0) ? 1 : 2) - 1) % 4;
                            sch_v[k][p][due]  = rv;
                            sch_ok[k][p][due] = 1'b1;
                        end
                    end
                    coll_e[k] = pce[0] && pwe[0] && pce[1] && pwe[1] &&
                                (pa[0] == pa[1]) && (int'(pa[0]) < dep(k));
                    for (int p = 1; p >= 0; p--) begin
                        if (pce[p] && pwe[p] && int'(pa[p]) < dep(k))
                            for (int i = 0; i < 2; i++) if (pm[p][i]) mm[k][pa[p]][i] = pd[p][i];
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (sch_ok[k][p][ncyc % 4]) begin
                        q_e[k][p] = sch_v[k][p][ncyc % 4];
                        sch_ok[k][p][ncyc % 4] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && rstn) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model busy[%0d]", k), {1'b0, busy_w[k]}, {1'b0, cnt_m[k] < dep(k)});
                chk($sformatf("model coll[%0d]", k), {1'b0, coll_w[k]}, {1'b0, coll_e[k]});
                chk($sformatf("model q0[%0d]", k), q0_w[k], q_e[k][0]);
                chk($sformatf("model q1[%0d]", k), q1_w[k], q_e[k][1]);
            end
        end
    end

    task automatic op(input logic c0, input logic w0, input logic [2:0] ad0, input logic [1:0] dd0,
                      input logic [1:0] mk0, input logic c1, input logic w1, input logic [2:0] ad1,
                      input logic [1:0] dd1, input logic [1:0] mk1);
        ce0 = c0; we0 = w0; a0 = ad0; d0 = dd0; wem0 = mk0;
        ce1 = c1; we1 = w1; a1 = ad1; d1 = dd1; wem1 = mk1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Counts edges on which each bank's busy flag was high, starting just after RSTN rises.
    task automatic count_sweep(input string tag);
        int  n0, n1, guard;
        bit  b0, b1;
        n0 = 0; n1 = 0; guard = 0;
        while ((busy_w[0] || busy_w[1]) && guard < 50) begin
            b0 = busy_w[0]; b1 = busy_w[1];
            @(posedge clk); #1;
            if (b0) n0++;
            if (b1) n1++;
            guard++;
        end
        chk({tag, " sweep len d8"}, 2'(n0), 2'(8 % 4));
        checks++;
        if (n0 != 8) begin errors++; $display("FAIL %s sweep cycles d8: got %0d expected 8", tag, n0); end
        checks++;
        if (n1 != 6) begin errors++; $display("FAIL %s sweep cycles d6: got %0d expected 6", tag, n1); end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        started = 1'b1;
        #1;
        chk("reset busy d8", {1'b0, busy_w[0]}, 2'b01);
        chk("reset q0 d8", q0_w[0], 2'b00);
        chk("reset coll d6", {1'b0, coll_w[1]}, 2'b00);
        @(negedge clk); #2 rstn = 1'b1;
        count_sweep("first");

        for (int a = 0; a < 8; a++) op(1, 0, 3'(a), 0, 0, 1, 0, 3'(7 - a), 0, 0);
        idle(2);

        op(1, 1, 3'd3, 2'b11, 2'b11, 0, 0, 0, 0, 0);
        op(1, 1, 3'd3, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0, 3'd3, 0, 0);
        idle(2);
        chk("masked write q1 d8", q1_w[0], 2'b10);
        chk("masked write q1 d6", q1_w[1], 2'b10);

        op(1, 1, 3'd5, 2'b10, 2'b11, 0, 0, 0, 0, 0);
        op(1, 1, 3'd5, 2'b01, 2'b11, 1, 0, 3'd5, 0, 0);
        idle(2);
        chk("mixed rw old d8", q1_w[0], 2'b10);
        chk("mixed rw old d6", q1_w[1], 2'b10);
        op(0, 0, 0, 0, 0, 1, 0, 3'd5, 0, 0);
        idle(2);
        chk("reread new d8", q1_w[0], 2'b01);
        chk("reread new d6", q1_w[1], 2'b01);

        op(1, 1, 3'd7, 2'b01, 2'b01, 1, 1, 3'd7, 2'b10, 2'b11);
        chk("coll pulse d8", {1'b0, coll_w[0]}, 2'b01);
        chk("coll oob d6", {1'b0, coll_w[1]}, 2'b00);
        idle(1);
        chk("coll drop d8", {1'b0, coll_w[0]}, 2'b00);
        op(1, 0, 3'd7, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        chk("dual write d8", q0_w[0], 2'b11);
        chk("oob read d6", q0_w[1], 2'b00);

        op(1, 1, 3'd4, 2'b01, 2'b01, 1, 1, 3'd4, 2'b10, 2'b10);
        chk("coll disjoint d8", {1'b0, coll_w[0]}, 2'b01);
        chk("coll disjoint d6", {1'b0, coll_w[1]}, 2'b01);

        op(1, 1, 3'd2, 2'b00, 2'b11, 0, 0, 0, 0, 0);
        op(1, 1, 3'd2, 2'b11, 2'b10, 0, 0, 0, 0, 0);
        chk("rdw merged d8", q0_w[0], 2'b10);
        op(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 0, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("hold q0 d8 c%0d", i), q0_w[0], 2'b10);
            if (i > 0) chk($sformatf("hold q0 d6 c%0d", i), q0_w[1], 2'b10);
        end

        #2 rstn = 1'b0;
        #1;
        chk("async q0 d8", q0_w[0], 2'b00);
        chk("async q0 d6", q0_w[1], 2'b00);
        chk("async busy d6", {1'b0, busy_w[1]}, 2'b01);
        @(negedge clk); #2 rstn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #2 rstn = 1'b0;
        #1;
        chk("midsweep busy d8", {1'b0, busy_w[0]}, 2'b01);
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b1; a0 = 3'd1; d0 = 2'b11; wem0 = 2'b11;
        #2 rstn = 1'b1;
        count_sweep("restart");
        idle(1);

        for (int a = 0; a < 8; a++) op(1, 0, 3'(a), 0, 0, 1, 0, 3'(7 - a), 0, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m20k_dp_bank.md
Name: m20k_dp_bank

Overview:
- Parametrised true-dual-port RAM bank; next generation of the fixed-geometry M20K dual-port wrappers in tech/stratixv.
- Behavioural array, inferable into M20K. Width and depth are generic.
- Adds behaviour the fixed wrappers lack: per-bit write mask, defined collision policy, optional output register, and a post-reset zero-initialisation sweep with a busy flag.

Parameters:
WIDTH, 2, data word width in bits (>=1)
DEPTH, 8192, number of words (>=2)
AW, 13, address width; must equal clog2(DEPTH)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
INIT_ZERO, 1, 1 = clear whole array after reset; 0 = no clear

Ports:
CLK  in  1  clock; all logic on rising edge
RSTN  in  1  asynchronous, active-low reset
A0  in  AW  port 0 address
A1  in  AW  port 1 address
D0  in  WIDTH  port 0 write data
D1  in  WIDTH  port 1 write data
CE0  in  1  port 0 enable
CE1  in  1  port 1 enable
WE0  in  1  port 0 write (valid only with CE0)
WE1  in  1  port 1 write (valid only with CE1)
WEM0  in  WIDTH  port 0 per-bit write mask, 1 = write bit
WEM1  in  WIDTH  port 1 per-bit write mask
Q0  out  WIDTH  port 0 read data
Q1  out  WIDTH  port 1 read data
INIT_BUSY  out  1  high while the clear sweep runs; ports ignored
COLL  out  1  one-cycle pulse: both ports wrote the same address

Behaviour:
Reset (RSTN low, async):
- Q0, Q1, all pipeline registers = 0; COLL = 0.
- INIT_BUSY = INIT_ZERO; clear counter = 0.
- Array contents are not reset asynchronously.

FSM:
- States are CLEAR and READY.
- Reset enters CLEAR if INIT_ZERO=1, else READY.
- CLEAR: each cycle writes all-zero to mem[cnt] and increments cnt. After the write at DEPTH-1, moves to READY. INIT_BUSY is 1 for exactly DEPTH cycles after RSTN rises.
- Reset asserted mid-sweep: the sweep restarts at address 0.
- During CLEAR: CE0/CE1 are ignored, Q0/Q1 hold 0, COLL stays 0.

Port operation (READY; each port independent):
- Read (CE & ~WE): Qn = mem[An] at the next edge (OUT_REG=0), or one cycle later (OUT_REG=1).
- Write (CE & WE): bit i of mem[An] takes Dn[i] where WEMn[i]=1; other bits are unchanged.
- Same-port read-during-write: Qn returns the full merged word (new data on masked bits, old data elsewhere), with the same latency as a read.
- Idle (CE=0): Qn holds its last value. With OUT_REG=1, the output stage also holds.
- Mixed-port read/write, same address, same cycle: the reading port returns OLD data. This is deterministic, not don't-care.
- Dual write, same address: per bit, port 0 wins where WEM0[i]=1; otherwise port 1 where WEM1[i]=1. COLL=1 on the following cycle for one cycle. COLL is raised even if the masks are disjoint.
- Dual write, different addresses: no interaction.
- Addresses >= DEPTH (non-power-of-2 DEPTH): the write is dropped and the read returns 0. COLL is not affected.

Test Plan:
- Reset release, INIT_ZERO=1, DEPTH=8 -> INIT_BUSY=1 for exactly 8 cycles. Afterwards a read of every address on both ports returns 0.
- Port 0 writes A=3 D=2'b11 WEM=11. Next cycle port 0 writes A=3 D=2'b00 WEM=2'b01. Port 1 then reads A=3 -> Q1=2'b10 one cycle later (two cycles with OUT_REG=1).
- Same cycle: port 0 writes A=5 D=01, port 1 reads A=5 (mem[5]=10 beforehand) -> Q1=10. A following read of A=5 gives 01.
- Both ports write A=7: D0=01 WEM0=01, D1=10 WEM1=11 -> mem[7]=11 and COLL pulses high for one cycle.
- Pulse RSTN low after 4 sweep cycles -> Q0/Q1=0 immediately. The sweep restarts and INIT_BUSY is high for a full DEPTH cycles.
- Read A=2 (value 10), then hold CE0=0 for 3 cycles -> Q0 stays 10 throughout.
